// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state encoding and opcode legality for alu_mc.
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  function automatic logic op_legal(input logic [3:0] op, input logic mul_en);
    return (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR}) || (mul_en && op == OP_MUL);
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational AND/OR/ADD/SUB/SLT/NOR with signed overflow; unknown opcodes give 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_ov
);
  logic             w_sub;
  logic             w_ovf;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  assign w_sub = (i_op == OP_SUB) || (i_op == OP_SLT);
  assign w_b   = w_sub ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
  // carry into the MSB is recovered from the MSB sum bit and its two inputs
  assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1] ^ i_a[WIDTH-1] ^ w_b[WIDTH-1];
  always_comb begin
    o_y  = (i_op == OP_AND) ? (i_a & i_b) :
           (i_op == OP_OR)  ? (i_a | i_b) :
           (i_op == OP_ADD || i_op == OP_SUB) ? w_sum[WIDTH-1:0] :
           (i_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf} :
           (i_op == OP_NOR) ? ~(i_a | i_b) : '0;
    o_ov = (i_op == OP_ADD || i_op == OP_SUB) && w_ovf;
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready accept, single-cycle logic/arith ops and
// a WIDTH-cycle unsigned shift-add multiplier; results held from DONE until the next accept.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             done_o,
  output logic             illegal_o
);
  localparam int CW = $clog2(WIDTH);

  state_t             r_state, w_next;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_res, r_hi;
  logic               r_ov, r_ill;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic               w_acc, w_is_mul, w_last, w_ov;
  logic [WIDTH-1:0]   w_y;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_pnext;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y),
    .o_ov (w_ov)
  );

  assign ready_o     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign done_o      = (r_state == S_DONE);
  assign result_o    = r_res;
  assign result_hi_o = r_hi;
  assign zero_o      = (r_res == '0);
  assign overflow_o  = r_ov;
  assign illegal_o   = r_ill;
  assign w_acc       = valid_i && ready_o;
  assign w_is_mul    = (ctrl_i == OP_MUL) && MUL_EN;
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  // r_p = {partial high half, remaining multiplier bits}; shifts right one bit per cycle
  assign w_sum       = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_pnext     = {w_sum, r_p[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_acc ? (w_is_mul ? S_MUL : S_EXEC) : S_IDLE;
      S_EXEC:         w_next = S_DONE;
      S_MUL:          w_next = w_last ? S_DONE : S_MUL;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_hi    <= '0;
      r_ov    <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_op  <= ctrl_i;
        r_a   <= src1_i;
        r_b   <= src2_i;
        r_p   <= {{WIDTH{1'b0}}, src2_i};
        r_cnt <= '0;
      end else if (r_state == S_MUL) begin
        r_p   <= w_pnext;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_res <= w_y;
        r_hi  <= '0;
        r_ov  <= w_ov;
        r_ill <= !op_legal(r_op, MUL_EN);
      end else if (r_state == S_MUL && w_last) begin
        r_res <= w_pnext[WIDTH-1:0];
        r_hi  <= w_pnext[2*WIDTH-1:WIDTH];
        r_ov  <= 1'b0;
        r_ill <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against a cycle-count/arithmetic model.
module tb_alu_mc;
  import alu_pkg::*;
  localparam int W = 32;

  logic         clk = 0, rst = 1, valid_i = 0;
  logic [3:0]   ctrl_i = 0;
  logic [W-1:0] src1_i = 0, src2_i = 0;
  logic         ready_o, done_o, zero_o, overflow_o, illegal_o;
  logic [W-1:0] result_o, result_hi_o;

  logic       v2 = 0;
  logic [3:0] c2 = 0;
  logic [7:0] a2 = 0, b2 = 0, r2, h2;
  logic       rd2, z2, o2, d2, il2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .result_o(result_o), .result_hi_o(result_hi_o),
    .zero_o(zero_o), .overflow_o(overflow_o), .done_o(done_o), .illegal_o(illegal_o)
  );

  alu_mc #(.WIDTH(8), .MUL_EN(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(v2), .ready_o(rd2), .ctrl_i(c2),
    .src1_i(a2), .src2_i(b2), .result_o(r2), .result_hi_o(h2),
    .zero_o(z2), .overflow_o(o2), .done_o(d2), .illegal_o(il2)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ov;
    logic         ill;
  } res_t;

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W-1:0] s;
    r = '0;
    case (op)
      OP_AND: r.lo = a & b;
      OP_OR:  r.lo = a | b;
      OP_NOR: r.lo = ~(a | b);
      OP_ADD: begin s = a + b; r.lo = s; r.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
      OP_SUB: begin s = a - b; r.lo = s; r.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
      OP_SLT: r.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_MUL: {r.hi, r.lo} = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Model: n counts edges; an op accepted on edge k completes on edge k+1 (EXEC) or k+W (MUL).
  longint n = 0, done_at = -1;
  res_t   pend = '0, exp_r = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_at <= -1;
      exp_r   <= '0;
    end else begin
      n <= n + 1;
      if (valid_i && n >= done_at) begin
        pend    <= model(ctrl_i, src1_i, src2_i);
        done_at <= n + 1 + ((ctrl_i == OP_MUL) ? W : 1);
      end
      if (n + 1 == done_at) exp_r <= pend;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise, output int lat);
    int t = 0;
    while (!ready_o && t < 100) begin @(negedge clk); t++; end
    valid_i = 1; ctrl_i = op; src1_i = a; src2_i = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid_i = 0;
    while (!done_o && lat < 100) begin
      if (noise) begin
        valid_i = 1'($urandom_range(0, 1)); ctrl_i = 4'($urandom);
        src1_i = $urandom; src2_i = $urandom;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      valid_i = 0;
    end
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL timeout waiting for done_o: op=%h lat=%0d", op, lat);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, cnt;
    logic [3:0] ops [8];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b0000};
    repeat (2) @(negedge clk);
    chk("reset result", result_o, 0);
    chk("reset zero/ready/done/ov/ill", {zero_o, ready_o, done_o, overflow_o, illegal_o}, 5'b11000);
    @(posedge clk);
    #2 rst = 0;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          checks++;
          if (done_o !== (n == done_at) || ready_o !== (n >= done_at) || result_o !== exp_r.lo ||
              result_hi_o !== exp_r.hi || overflow_o !== exp_r.ov || illegal_o !== exp_r.ill ||
              zero_o !== (exp_r.lo == 0)) begin
            errors++;
            $display("FAIL cycle %0d: done=%b ready=%b res=%h hi=%h ov=%b ill=%b zero=%b, expected done=%b ready=%b res=%h hi=%h ov=%b ill=%b",
                     n, done_o, ready_o, result_o, result_hi_o, overflow_o, illegal_o, zero_o,
                     n == done_at, n >= done_at, exp_r.lo, exp_r.hi, exp_r.ov, exp_r.ill);
          end
        end
      end
    join_none
    @(negedge clk);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, lat);
    chk("add latency", lat, 2);
    chk("add result", result_o, 32'h8000_0000);
    chk("add ov/zero", {overflow_o, zero_o}, 2'b10);
    issue(OP_SUB, 5, 5, 0, lat);
    chk("sub result", result_o, 0);
    chk("sub zero/ov", {zero_o, overflow_o}, 2'b10);
    issue(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 0, lat);
    chk("slt min<max", result_o, 1);
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, lat);
    chk("slt max<min", result_o, 0);
    issue(OP_MUL, '1, '1, 1, lat);
    chk("mul latency", lat, 33);
    chk("mul hi", result_hi_o, 32'hFFFF_FFFE);
    chk("mul lo", result_o, 32'h0000_0001);
    issue(OP_AND, 32'hF0F0, 32'hFF00, 0, lat);
    chk("back-to-back spacing", lat, 2);
    chk("and result/hi", {result_hi_o, result_o}, 64'h0000_F000);
    issue(4'b1111, 32'h1234, 32'h5678, 0, lat);
    chk("illegal latency", lat, 2);
    chk("illegal flags", {illegal_o, result_o, result_hi_o, overflow_o}, {1'b1, 65'h0});
    issue(OP_OR, 32'h00A0, 32'h0005, 0, lat);
    chk("or result", result_o, 32'h00A5);
    valid_i = 1; ctrl_i = OP_MUL; src1_i = 3; src2_i = 7;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0;
    repeat (9) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid-mul reset outputs", {result_o, result_hi_o, zero_o, ready_o, done_o, illegal_o}, {64'h0, 4'b1100});
    #1 rst = 0;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (done_o) cnt++; end
    chk("no done after abort", cnt, 0);
    v2 = 1; c2 = OP_MUL; a2 = 3; b2 = 5;
    @(posedge clk);
    @(negedge clk);
    v2 = 0;
    chk("mul_en=0 not done yet", {d2, rd2}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("mul_en=0 illegal", {d2, il2, r2, h2, z2, o2}, {2'b11, 16'h0, 2'b10});
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ctrl_i = ops[$urandom_range(0, 7)];
      if (ctrl_i == 4'b0000 && $urandom_range(0, 1) == 1) ctrl_i = 4'($urandom);
      issue(ctrl_i, pick(), pick(), 1'($urandom_range(0, 1)), lat);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 Parameter: MUL_EN, default 1, MUL opcode supported when 1; treated as illegal when 0.
REQ-003 Port: clk_i  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: valid_i  input  1  operand/opcode offer.
REQ-006 Port: ready_o  output  1  block can accept an offer this cycle.
REQ-007 Port: ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL.
REQ-008 Port: src1_i  input  WIDTH  operand A.
REQ-009 Port: src2_i  input  WIDTH  operand B.
REQ-010 Port: result_o  output  WIDTH  result, low half for MUL.
REQ-011 Port: result_hi_o  output  WIDTH  MUL high half; 0 for all other ops.
REQ-012 Port: zero_o  output  1  result_o == 0.
REQ-013 Port: overflow_o  output  1  signed overflow, ADD/SUB only; 0 otherwise.
REQ-014 Port: done_o  output  1  one-cycle pulse; all result outputs valid and held until the next accept.
REQ-015 Port: illegal_o  output  1  accepted opcode not in list; qualifies done_o.

Function
REQ-016 Accept occurs on a rising edge with valid_i=1 and ready_o=1; operands and opcode are registered at accept.
REQ-017 FSM states: IDLE, EXEC, MUL, DONE; ready_o=1 only in IDLE and DONE.
REQ-018 IDLE/DONE + accept of non-MUL -> EXEC; + accept of MUL -> MUL; DONE without accept -> IDLE.
REQ-019 EXEC lasts exactly 1 cycle, then DONE; done_o=1 in DONE (latency 2 edges from accept).
REQ-020 MUL: unsigned shift-add, one multiplier bit per cycle, counter 0..WIDTH-1, exactly WIDTH cycles, then DONE.
REQ-021 ADD/SUB: SUB = A + ~B + 1; result is modulo 2^WIDTH; overflow = carry into MSB XOR carry out of MSB.
REQ-022 SLT: signed compare; result_o = {WIDTH-1 zeros, (A-B) sign XOR overflow}; correct at both extremes.
REQ-023 NOR = ~(A|B); AND/OR bitwise.
REQ-024 Illegal opcode: result_o=0, result_hi_o=0, overflow_o=0, illegal_o=1, latency same as EXEC.
REQ-025 Accept in DONE starts the next op back-to-back; done_o still pulses for exactly that one cycle.
REQ-026 valid_i while busy (EXEC/MUL) is ignored; no queuing; operand changes mid-op have no effect.
REQ-027 Outputs change only on the edge entering DONE; stable otherwise.

Reset
REQ-028 rst_i asserted, at any time, forces IDLE; result_o, result_hi_o, zero_o cleared to 0/0/1? no: zero_o=1 consistent with result_o=0.
REQ-029 Reset also clears overflow_o, done_o, illegal_o, counter and operand registers to 0; ready_o=1.
REQ-030 Reset mid-MUL aborts silently: no done_o pulse after release.

Structure
REQ-031 Package alu_pkg holds opcode constants, FSM state enum, and opcode-legal function.
REQ-032 One sub-module alu_core: combinational WIDTH-bit AND/OR/ADD/SUB/SLT/NOR with overflow; FSM, MUL datapath, and output registers live in alu_mc.

Verification
REQ-033 WIDTH=32: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow 1, zero 0, done 2 edges after accept.
REQ-034 SUB 5-5 -> result 0, zero 1, overflow 0; SLT 0x80000000 vs 0x7FFFFFFF -> result 1.
REQ-035 MUL 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001, done exactly 33 edges after accept, ready_o=0 in between.
REQ-036 Back-to-back: accept AND in DONE of prior op -> two done pulses separated by exactly 2 cycles; valid_i during MUL ignored.
REQ-037 rst_i pulse at MUL cycle 10 -> outputs cleared immediately, ready_o=1, no done_o afterwards.
REQ-038 ctrl_i=1111 -> illegal_o=1, result 0, done after 2 edges; MUL_EN=0 with MUL -> same.
